// File: rtl/bin2x2_filter.sv
// rtl/bin2x2_filter.sv - 2x2 mean binning of a raster pixel stream, valid/ready on both sides
// Optional BIN2X2_ROUND_EN: round-half-up instead of truncating the 2x2 mean.
module bin2x2_filter #(
  parameter int PIXEL_BIT_WIDTH = 12,
  parameter int IN_ROWS         = 20,
  parameter int IN_COLS         = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int P        = PIXEL_BIT_WIDTH;
  localparam int CW       = $clog2(IN_COLS + 1);
  localparam int RW       = $clog2(IN_ROWS + 1);
  localparam int AW       = CW - 1;
  localparam int LB_DEPTH = IN_COLS / 2;

  logic [CW-1:0]  r_col;
  logic [RW-1:0]  r_row;
  logic [P:0]     r_h_acc;
  logic [P:0]     r_linebuf [LB_DEPTH];
  logic [P-1:0]   r_pixel_out;
  logic           r_out_valid;

  logic           w_accept;
  logic           w_col_last;
  logic           w_row_last;
  logic           w_col_odd;
  logic           w_row_odd;
  logic           w_lb_wr;
  logic           w_load;
  logic [AW-1:0]  w_lb_idx;
  logic [P:0]     w_lb_rd;
  logic [P:0]     w_pair_sum;
  logic [P+1:0]   w_sum;
  logic [P+1:0]   w_sum_adj;
  logic [P-1:0]   w_mean;

  // A held output stalls every input beat, not just the ones that would produce an output.
  assign in_ready   = reset && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;

  assign w_col_last = (r_col == CW'(IN_COLS - 1));
  assign w_row_last = (r_row == RW'(IN_ROWS - 1));
  assign w_col_odd  = r_col[0];
  assign w_row_odd  = r_row[0];

  assign w_lb_idx   = r_col[CW-1:1];
  assign w_lb_rd    = r_linebuf[w_lb_idx];
  assign w_pair_sum = r_h_acc + {1'b0, pixel_in};
  assign w_sum      = {1'b0, w_lb_rd} + {1'b0, r_h_acc} + {2'b00, pixel_in};

`ifdef BIN2X2_ROUND_EN
  assign w_sum_adj  = w_sum + (P+2)'(2);
`else
  assign w_sum_adj  = w_sum;
`endif
  assign w_mean     = P'(w_sum_adj >> 2);

  assign w_lb_wr    = w_accept && w_col_odd && !w_row_odd;
  assign w_load     = w_accept && w_col_odd && w_row_odd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h_acc <= '0;
    end else if (w_accept && !w_col_odd) begin
      r_h_acc <= {1'b0, pixel_in};
    end
  end

  // Line buffer holds the horizontal pair sums of the even row; it is never cleared.
  always_ff @(posedge clk) begin
    if (w_lb_wr) begin
      r_linebuf[w_lb_idx] <= w_pair_sum;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pixel_out <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_pixel_out <= w_mean;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign pixel_out = r_pixel_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_bin2x2_filter.sv
// tb/tb_bin2x2_filter.sv - directed bench for bin2x2_filter (4x4 and 20x20 instances)
// Expected values follow BIN2X2_ROUND_EN when it is defined.
module tb_bin2x2_filter;

`ifdef BIN2X2_ROUND_EN
  localparam int RND = 2;
  localparam int R0 = 3, R1 = 5, R2 = 11, R3 = 13;
`else
  localparam int RND = 0;
  localparam int R0 = 2, R1 = 4, R2 = 10, R3 = 12;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [11:0] s_pixel_in = '0;
  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [11:0] s_pixel_out;
  logic        s_out_valid;
  logic        s_out_ready = 1'b1;

  logic [11:0] b_pixel_in = '0;
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [11:0] b_pixel_out;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;
  int s_got[$];
  int b_got[$];
  int b_exp[$];
  logic [11:0] img [2][20][20];

  always #5 clk = ~clk;

  bin2x2_filter #(.PIXEL_BIT_WIDTH(12), .IN_ROWS(4), .IN_COLS(4)) u_small (
    .clk(clk), .reset(rst_n),
    .pixel_in(s_pixel_in), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .pixel_out(s_pixel_out), .out_valid(s_out_valid), .out_ready(s_out_ready)
  );

  bin2x2_filter #(.PIXEL_BIT_WIDTH(12), .IN_ROWS(20), .IN_COLS(20)) u_big (
    .clk(clk), .reset(rst_n),
    .pixel_in(b_pixel_in), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .pixel_out(b_pixel_out), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  // Handshakes are sampled on the falling edge; inputs only change just after the rising edge.
  always @(negedge clk) begin
    if (s_out_valid && s_out_ready) s_got.push_back(int'(s_pixel_out));
    if (b_out_valid && b_out_ready) b_got.push_back(int'(b_pixel_out));
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_px(input logic [11:0] p);
    bit ok = 0;
    s_pixel_in = p;
    s_in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_in_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    if (!ok) check("push_timeout", 0, 1);
  endtask

  task automatic push_ramp();
    for (int i = 0; i < 16; i++) push_px(12'(i));
  endtask

  task automatic check_q4(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    check({tag, "_count"}, s_got.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_out%0d", tag, i), (i < s_got.size()) ? s_got[i] : -1, e[i]);
    s_got.delete();
  endtask

  initial begin
    // Reset state
    cycles(3);
    @(negedge clk);
    check("rst_out_valid", int'(s_out_valid), 0);
    check("rst_pixel_out", int'(s_pixel_out), 0);
    check("rst_in_ready", int'(s_in_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(2);

    // Constant frame
    for (int i = 0; i < 16; i++) push_px(12'd100);
    cycles(3);
    check_q4("const", 100, 100, 100, 100);
    @(negedge clk);
    check("const_idle_valid", int'(s_out_valid), 0);
    cycles(1);

    // Ramp
    push_ramp();
    cycles(3);
    check_q4("ramp", R0, R1, R2, R3);

    // Full scale
    for (int i = 0; i < 16; i++) push_px(12'd4095);
    cycles(3);
    check_q4("full", 4095, 4095, 4095, 4095);

    // Backpressure from the first beat
    s_out_ready = 1'b0;
    fork
      push_ramp();
      begin
        bit seen = 0;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (s_out_valid) begin
            seen = 1;
            break;
          end
        end
        check("bp_first_valid", int'(seen), 1);
        check("bp_first_pixel", int'(s_pixel_out), R0);
        check("bp_in_ready", int'(s_in_ready), 0);
        repeat (4) @(negedge clk);
        check("bp_held_pixel", int'(s_pixel_out), R0);
        check("bp_held_valid", int'(s_out_valid), 1);
        check("bp_held_in_ready", int'(s_in_ready), 0);
        @(posedge clk); #1;
        s_out_ready = 1'b1;
      end
    join
    cycles(3);
    check_q4("bp", R0, R1, R2, R3);

    // Reset mid-frame: the 6th pixel completes a block whose output must be dropped
    for (int i = 0; i < 6; i++) push_px(12'(i));
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", int'(s_out_valid), 0);
    check("midrst_in_ready", int'(s_in_ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(1);
    check("midrst_no_output", s_got.size(), 0);
    push_ramp();
    cycles(3);
    check_q4("midrst", R0, R1, R2, R3);

    // Two back-to-back 20x20 frames at full rate
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 20; r++)
        for (int c = 0; c < 20; c++)
          img[f][r][c] = 12'($urandom_range(0, 4095));
    img[1][0][0] = 12'd4095; img[1][0][1] = 12'd4095;
    img[1][1][0] = 12'd4095; img[1][1][1] = 12'd4095;
    for (int f = 0; f < 2; f++)
      for (int br = 0; br < 10; br++)
        for (int bc = 0; bc < 10; bc++)
          b_exp.push_back((int'(img[f][2*br][2*bc]) + int'(img[f][2*br][2*bc+1]) +
                           int'(img[f][2*br+1][2*bc]) + int'(img[f][2*br+1][2*bc+1]) + RND) / 4);
    begin
      int stalls = 0;
      for (int f = 0; f < 2; f++)
        for (int r = 0; r < 20; r++)
          for (int c = 0; c < 20; c++) begin
            b_pixel_in = img[f][r][c];
            b_in_valid = 1'b1;
            @(negedge clk);
            if (!b_in_ready) stalls++;
            @(posedge clk); #1;
          end
      b_in_valid = 1'b0;
      check("b2b_stalls", stalls, 0);
    end
    cycles(4);
    check("b2b_count", b_got.size(), 200);
    for (int i = 0; i < 200; i++)
      check($sformatf("b2b_out%0d", i), (i < b_got.size()) ? b_got[i] : -1, b_exp[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
